// File: rtl/razor_reg_file_p.sv
// razor_reg_file_p -- NREG x DATA_W Razor register file with shadow check.
//
// Two combinational read ports and one write port. Each accepted write is
// compared one cycle later against a late-sampled copy of the write data
// (inW_shd). On a mismatch the entry is restored from the shadow copy
// through a two-cycle stall (CHECK + RECOVER). A sticky per-register error
// map and a saturating error counter record every recovery.
//
// Optional build macro RAZOR_FWD_EN: when defined, an accepted write is
// forwarded to a read port addressing the same register in the same cycle.
// When undefined, reads return stored contents only.
module razor_reg_file_p #(
   parameter int DATA_W   = 32,
   parameter int ADDR_W   = 5,
   parameter int ZERO_REG = 1,
   parameter int ECNT_W   = 8
) (
   input  logic                   clk,
   input  logic                   ireset,
   input  logic                   we,
   input  logic [ADDR_W-1:0]      rw,
   input  logic [DATA_W-1:0]      inW,
   input  logic [DATA_W-1:0]      inW_shd,
   input  logic [ADDR_W-1:0]      ra,
   input  logic [ADDR_W-1:0]      rb,
   output logic [DATA_W-1:0]      outA,
   output logic [DATA_W-1:0]      outB,
   output logic                   stall,
   output logic                   oerror,
   input  logic                   err_clr,
   output logic [2**ADDR_W-1:0]   err_map,
   output logic [ECNT_W-1:0]      err_cnt
);

   localparam int NREG = 2**ADDR_W;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_CHECK,
      ST_RECOVER
   } state_t;

   state_t              state_reg;
   state_t              state_next;
   logic [DATA_W-1:0]   mem_reg [NREG];
   logic [DATA_W-1:0]   shd_q_reg;
   logic [ADDR_W-1:0]   chk_addr_reg;
   logic [ECNT_W-1:0]   err_cnt_reg;
   logic                mis;
   logic                accept;
   logic                recover_wr;
   logic                rw_is_zero;

   // Shadow compare, stall/error generation and write acceptance
   always_comb begin
      rw_is_zero = (ZERO_REG != 0) && (rw == '0);
      mis        = (state_reg == ST_CHECK) && (mem_reg[chk_addr_reg] != shd_q_reg);
      recover_wr = (state_reg == ST_RECOVER);
      stall      = mis || recover_wr;
      oerror     = mis;
      accept     = we && !stall && !rw_is_zero;
   end

   // Recovery FSM state register
   always_ff @(posedge clk) begin
      if (!ireset) begin
         state_reg <= ST_IDLE;
      end else begin
         state_reg <= state_next;
      end
   end

   // Recovery FSM next-state logic; a clean CHECK re-arms on a new write
   always_comb begin
      state_next = state_reg;
      case (state_reg)
         ST_IDLE:    state_next = accept ? ST_CHECK : ST_IDLE;
         ST_CHECK: begin
            if (mis) begin
               state_next = ST_RECOVER;
            end else if (accept) begin
               state_next = ST_CHECK;
            end else begin
               state_next = ST_IDLE;
            end
         end
         ST_RECOVER: state_next = ST_IDLE;
         default:    state_next = ST_IDLE;
      endcase
   end

   // Main storage: normal writes, or restore from shadow during RECOVER
   always_ff @(posedge clk) begin
      if (!ireset) begin
         for (int i = 0; i < NREG; i++) begin
            mem_reg[i] <= '0;
         end
      end else if (accept) begin
         mem_reg[rw] <= inW;
      end else if (recover_wr) begin
         mem_reg[chk_addr_reg] <= shd_q_reg;
      end
   end

   // Shadow copy and address of the write awaiting its check
   always_ff @(posedge clk) begin
      if (!ireset) begin
         shd_q_reg    <= '0;
         chk_addr_reg <= '0;
      end else if (accept) begin
         shd_q_reg    <= inW_shd;
         chk_addr_reg <= rw;
      end
   end

   // Sticky error map, one bit per register; a recovery set beats err_clr
   generate
      for (genvar gi = 0; gi < NREG; gi++) begin : g_err_map
         always_ff @(posedge clk) begin
            if (!ireset) begin
               err_map[gi] <= 1'b0;
            end else if (recover_wr && (chk_addr_reg == ADDR_W'(gi))) begin
               err_map[gi] <= 1'b1;
            end else if (err_clr) begin
               err_map[gi] <= 1'b0;
            end
         end
      end
   endgenerate

   // Saturating count of recoveries
   always_ff @(posedge clk) begin
      if (!ireset) begin
         err_cnt_reg <= '0;
      end else if (recover_wr && (err_cnt_reg != {ECNT_W{1'b1}})) begin
         err_cnt_reg <= err_cnt_reg + 1'b1;
      end
   end

   assign err_cnt = err_cnt_reg;

   // Read port A: r0 zero, optional forward, corrected value while stalled
   always_comb begin
      outA = mem_reg[ra];
      if (stall && (ra == chk_addr_reg)) begin
         outA = shd_q_reg;
      end
`ifdef RAZOR_FWD_EN
      if (accept && (ra == rw)) begin
         outA = inW;
      end
`endif
      if ((ZERO_REG != 0) && (ra == '0)) begin
         outA = '0;
      end
   end

   // Read port B: same selection rules as port A
   always_comb begin
      outB = mem_reg[rb];
      if (stall && (rb == chk_addr_reg)) begin
         outB = shd_q_reg;
      end
`ifdef RAZOR_FWD_EN
      if (accept && (rb == rw)) begin
         outB = inW;
      end
`endif
      if ((ZERO_REG != 0) && (rb == '0)) begin
         outB = '0;
      end
   end

endmodule

// File: tb/tb_razor_reg_file_p.sv
// tb_razor_reg_file_p -- directed plus randomized bench for razor_reg_file_p.
// A register-file model with a pending-check slot and a recovery slot
// predicts every output each cycle; directed steps add fixed-value checks.
module tb_razor_reg_file_p;

   localparam int DW = 32;
   localparam int AW = 5;
   localparam int CW = 2;

   logic          clk = 1'b0;
   logic          ireset;
   logic          we;
   logic [AW-1:0] rw;
   logic [DW-1:0] inW;
   logic [DW-1:0] inW_shd;
   logic [AW-1:0] ra;
   logic [AW-1:0] rb;
   logic [DW-1:0] outA;
   logic [DW-1:0] outB;
   logic          stall;
   logic          oerror;
   logic          err_clr;
   logic [31:0]   err_map;
   logic [CW-1:0] err_cnt;

   razor_reg_file_p #(
      .DATA_W(DW), .ADDR_W(AW), .ZERO_REG(1), .ECNT_W(CW)
   ) dut (
      .clk(clk), .ireset(ireset), .we(we), .rw(rw), .inW(inW),
      .inW_shd(inW_shd), .ra(ra), .rb(rb), .outA(outA), .outB(outB),
      .stall(stall), .oerror(oerror), .err_clr(err_clr),
      .err_map(err_map), .err_cnt(err_cnt)
   );

   always #5 clk = ~clk;

   int n_cmp  = 0;
   int n_fail = 0;
   bit chk_en = 0;

   // Reference model state
   logic [DW-1:0] m_mem [32];
   bit            pend_v;
   logic [AW-1:0] pend_a;
   logic [DW-1:0] pend_s;
   bit            rec_v;
   logic [AW-1:0] rec_a;
   logic [DW-1:0] rec_s;
   logic [31:0]   m_map;
   int            m_cnt;
   bit            e_mis;
   bit            e_stall;
   bit            e_acc;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   function automatic logic [DW-1:0] m_read(input logic [AW-1:0] addr);
      if (addr == 0) return '0;
`ifdef RAZOR_FWD_EN
      if (e_acc && addr == rw) return inW;
`endif
      if (e_mis && addr == pend_a) return pend_s;
      if (rec_v && addr == rec_a) return rec_s;
      return m_mem[addr];
   endfunction

   // Apply inputs after the falling edge and compare against the model
   task automatic drive(input logic rstn_i, input logic we_i, input logic [AW-1:0] rw_i,
                        input logic [DW-1:0] w_i, input logic [DW-1:0] ws_i,
                        input logic [AW-1:0] ra_i, input logic [AW-1:0] rb_i,
                        input logic clr_i);
      @(negedge clk);
      ireset = rstn_i; we = we_i; rw = rw_i; inW = w_i; inW_shd = ws_i;
      ra = ra_i; rb = rb_i; err_clr = clr_i;
      #1;
      e_mis   = pend_v && (m_mem[pend_a] != pend_s);
      e_stall = e_mis || rec_v;
      e_acc   = we && !e_stall && (rw != 0);
      if (chk_en) begin
         check("stall",   64'(stall),   64'(e_stall));
         check("oerror",  64'(oerror),  64'(e_mis));
         check("outA",    64'(outA),    64'(m_read(ra)));
         check("outB",    64'(outB),    64'(m_read(rb)));
         check("err_map", 64'(err_map), 64'(m_map));
         check("err_cnt", 64'(err_cnt), 64'(m_cnt));
      end
   endtask

   // Advance one rising edge and update the model from the held inputs
   task automatic tick();
      @(posedge clk);
      if (!ireset) begin
         for (int i = 0; i < 32; i++) m_mem[i] = '0;
         pend_v = 0; rec_v = 0; m_map = '0; m_cnt = 0;
         chk_en = 1;
      end else begin
         if (err_clr) m_map = '0;
         if (rec_v) begin
            m_mem[rec_a] = rec_s;
            m_map[rec_a] = 1'b1;
            if (m_cnt < (1 << CW) - 1) m_cnt++;
            rec_v = 0;
         end
         if (e_mis) begin
            rec_v = 1; rec_a = pend_a; rec_s = pend_s; pend_v = 0;
         end else if (e_acc) begin
            m_mem[rw] = inW; pend_v = 1; pend_a = rw; pend_s = inW_shd;
         end else begin
            pend_v = 0;
         end
      end
   endtask

   task automatic idle(input logic [AW-1:0] ra_i, input logic [AW-1:0] rb_i);
      drive(1, 0, 0, 0, 0, ra_i, rb_i, 0);
      tick();
   endtask

   // Write with a corrupted main copy, then ride out CHECK and RECOVER
   task automatic inject(input logic [AW-1:0] a, input logic [DW-1:0] v);
      drive(1, 1, a, v, v ^ 32'h1, a, 0, 0);
      tick();
      idle(a, 0);
      idle(a, 0);
   endtask

   initial begin
      logic [DW-1:0] w;
      logic [DW-1:0] ws;

      // Reset held two cycles with a write asserted
      drive(0, 1, 3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 3, 0, 0); tick();
      drive(0, 1, 3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 3, 0, 0); tick();
      drive(1, 0, 0, 0, 0, 3, 0, 0);
      check("rst_outA", 64'(outA), 64'h0);
      check("rst_stall", 64'(stall), 64'h0);
      check("rst_cnt", 64'(err_cnt), 64'h0);
      check("rst_map", 64'(err_map), 64'h0);
      tick();

      // Clean write then read back
      drive(1, 1, 5, 32'h1234_5678, 32'h1234_5678, 0, 0, 0); tick();
      drive(1, 0, 0, 0, 0, 5, 0, 0);
      check("clean_outA", 64'(outA), 64'h1234_5678);
      check("clean_oerr", 64'(oerror), 64'h0);
      tick();

      // Three back-to-back clean writes, never stalled
      for (int i = 1; i <= 3; i++) begin
         drive(1, 1, AW'(i), 32'(i * 16'h1111), 32'(i * 16'h1111), AW'(i), 0, 0);
         check("b2b_stall", 64'(stall), 64'h0);
         tick();
      end
      drive(1, 0, 0, 0, 0, 1, 3, 0);
      check("b2b_stall_end", 64'(stall), 64'h0);
      check("b2b_r3", 64'(outB), 64'h3333);
      tick();

      // Timing error on r7; writes during both stall cycles are dropped
      drive(1, 1, 7, 32'hA5A5_A5A5, 32'hA5A5_A5A4, 7, 0, 0); tick();
      drive(1, 1, 8, 32'h1111, 32'h1111, 7, 0, 0);
      check("err_oerror", 64'(oerror), 64'h1);
      check("err_stall1", 64'(stall), 64'h1);
      check("err_outA", 64'(outA), 64'hA5A5_A5A4);
      tick();
      drive(1, 1, 9, 32'h2222, 32'h2222, 7, 0, 0);
      check("rec_stall2", 64'(stall), 64'h1);
      check("rec_oerror", 64'(oerror), 64'h0);
      tick();
      drive(1, 0, 0, 0, 0, 7, 8, 0);
      check("rec_mem7", 64'(outA), 64'hA5A5_A5A4);
      check("rec_r8_dropped", 64'(outB), 64'h0);
      check("rec_map", 64'(err_map), 64'h80);
      check("rec_cnt", 64'(err_cnt), 64'h1);
      tick();
      drive(1, 0, 0, 0, 0, 9, 0, 0);
      check("rec_r9_dropped", 64'(outA), 64'h0);
      tick();

      // Register 0 writes are dropped and never checked
      drive(1, 1, 0, 32'hDEAD, 32'hBEEF, 0, 0, 0); tick();
      drive(1, 0, 0, 0, 0, 0, 0, 0);
      check("r0_outA", 64'(outA), 64'h0);
      check("r0_oerror", 64'(oerror), 64'h0);
      check("r0_stall", 64'(stall), 64'h0);
      tick();

      // Four more errors (five total) saturate the 2-bit counter
      for (int i = 0; i < 4; i++) inject(AW'(11 + i), $urandom);
      drive(1, 0, 0, 0, 0, 0, 0, 0);
      check("sat_cnt", 64'(err_cnt), 64'h3);
      tick();

      // err_clr in the same cycle as the r9 recovery keeps only bit 9
      drive(1, 1, 9, 32'h9999, 32'h9998, 0, 0, 0); tick();
      idle(0, 0);
      drive(1, 0, 0, 0, 0, 9, 0, 1); tick();
      drive(1, 0, 0, 0, 0, 9, 0, 0);
      check("clr_map", 64'(err_map), 64'h200);
      check("clr_mem9", 64'(outA), 64'h9998);
      tick();

      // Reset during RECOVER discards the recovery
      drive(1, 1, 10, 32'hCAFE, 32'hCAFF, 0, 0, 0); tick();
      idle(10, 0);
      drive(0, 0, 0, 0, 0, 10, 0, 0); tick();
      drive(1, 0, 0, 0, 0, 10, 0, 0);
      check("mrst_stall", 64'(stall), 64'h0);
      check("mrst_cnt", 64'(err_cnt), 64'h0);
      check("mrst_outA", 64'(outA), 64'h0);
      check("mrst_map", 64'(err_map), 64'h0);
      tick();

      // Same-cycle write/read of r4
      drive(1, 1, 4, 32'h55, 32'h55, 4, 0, 0);
`ifdef RAZOR_FWD_EN
      check("fwd_outA", 64'(outA), 64'h55);
`else
      check("nofwd_outA", 64'(outA), 64'h0);
`endif
      tick();
      drive(1, 0, 0, 0, 0, 4, 0, 0);
      check("r4_after", 64'(outA), 64'h55);
      tick();

      // Randomized traffic against the model
      for (int n = 0; n < 600; n++) begin
         w  = $urandom;
         ws = ($urandom_range(0, 5) == 0) ? (w ^ (32'h1 << $urandom_range(0, 31))) : w;
         drive(($urandom_range(0, 63) != 0), ($urandom_range(0, 3) != 0),
               AW'($urandom_range(0, 31)), w, ws,
               AW'($urandom_range(0, 31)), AW'($urandom_range(0, 31)),
               ($urandom_range(0, 15) == 0));
         tick();
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
